matrix_scan_mux: RTL
====================

// Module: matrix_scan_mux
// PURPOSE
//  Parametrised successor of the 35:1 dot-matrix pixel mux. Holds a COLS x ROWS frame in a
//  double buffer and scans it column by column onto a multiplexed LED matrix, with a blanking
//  gap between columns. Keeps the legacy 1-based random-access pixel read (0 = invalid).
//  Sits between the frame producer (loader handshake) and the matrix column/row drivers.
// PARAMETERS
//  COLS   5     number of matrix columns (>=1)
//  ROWS   7     number of matrix rows (>=1)
//  DWELL  1000  cycles each column is lit (>=1)
//  BLANK  2     cycles all outputs are dark between columns (>=0; 0 = no gap)
// PORTS
//  CLK         in   1          single clock, all logic on rising edge
//  RST         in   1          synchronous, active-high reset
//  FRAME_IN    in   COLS*ROWS  frame; pixel (c,r) at bit c*ROWS+r (0-based c,r)
//  LOAD_VALID  in   1          producer offers FRAME_IN
//  LOAD_READY  out  1          shadow buffer free; transfer when VALID&&READY
//  EN          in   1          1 = scan, 0 = idle/dark
//  COL_EN      out  COLS       one-hot active column, active-high
//  ROW_DATA    out  ROWS       row bits of the active column
//  FRAME_DONE  out  1          1-cycle pulse at end of each full scan frame
//  PIX_COL     in   $clog2(COLS+1)  1-based column select, 0 or >COLS = invalid
//  PIX_ROW     in   $clog2(ROWS+1)  1-based row select, 0 or >ROWS = invalid
//  PIX_OUT     out  1          registered pixel of ACTIVE buffer at (PIX_COL,PIX_ROW)
// BEHAVIOUR
//  Reset: state IDLE; active and shadow buffers 0; pending=0; col=0; counter=0;
//   COL_EN=0, ROW_DATA=0, FRAME_DONE=0, PIX_OUT=0, LOAD_READY=0 during RST, 1 first cycle after.
//  All outputs registered. LOAD_READY = !pending.
//  Load: on VALID&&READY, shadow<=FRAME_IN, pending<=1 (READY low next cycle).
//  Promote (active<=shadow, pending<=0): at frame boundary if pending, or any cycle in
//   IDLE with pending. READY returns high the cycle after promotion. Active buffer never
//   changes mid-frame.
//  FSM states IDLE, SHOW, GAP:
//   IDLE: outputs dark; EN=1 -> SHOW col 0, counter 0; COL_EN[0] visible 1 cycle after EN sampled.
//   SHOW: COL_EN=onehot(col), ROW_DATA=active[col]; after DWELL cycles -> GAP (BLANK>0)
//    else next column directly.
//   GAP: COL_EN=0, ROW_DATA=0 for BLANK cycles, then SHOW col+1.
//   Column wrap COLS-1 -> 0 is the frame boundary: FRAME_DONE pulses on the first cycle of the
//    new frame's col 0 SHOW; promotion of pending frame takes effect for that col 0.
//  EN=0 in SHOW/GAP: -> IDLE next cycle, dark, col/counter cleared; pending/buffers kept.
//  COL_EN never has more than one bit set; no cycle shows two columns.
//  PIX read: 1-cycle latency; PIX_OUT = active[(PIX_COL-1)*ROWS+(PIX_ROW-1)] if both in range,
//   else 0. Independent of FSM state.
//  RST mid-operation: every state/output returns to reset values next edge; in-flight load lost.
// TESTING
//  Reset: hold RST 2 cycles mid-scan -> COL_EN=0, ROW_DATA=0, PIX_OUT=0, LOAD_READY=1 after.
//  Scan timing, DWELL=4 BLANK=1, COLS=5 ROWS=7: load frame, EN=1 -> each COL_EN one-hot 4 cycles,
//   1 dark cycle, order 00001..10000, FRAME_DONE every 25 cycles.
//  Double buffer: load A, scan, load B mid-frame -> READY=0, columns still show A until wrap,
//   col 0 of next frame shows B, READY=1 one cycle later.
//  Pixel read: frame with only (c=2,r=7) set -> PIX 2/7 -> 1 next cycle; 0/3, 6/1, 1/8 -> 0.
//  EN drop at col 3 SHOW -> dark next cycle; EN re-asserted -> restarts at col 0.
//  BLANK=0: columns back-to-back, no dark cycles, exactly one bit of COL_EN every SHOW cycle.

Source files
------------

// File: rtl/matrix_scan_mux.sv
// Double-buffered COLS x ROWS frame scanned column by column onto a multiplexed LED matrix,
// with a blanking gap between columns and a registered 1-based random-access pixel read.
module matrix_scan_mux #(
  parameter int COLS  = 5,
  parameter int ROWS  = 7,
  parameter int DWELL = 1000,
  parameter int BLANK = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [COLS*ROWS-1:0]         FRAME_IN,
  input  logic                         LOAD_VALID,
  output logic                         LOAD_READY,
  input  logic                         EN,
  output logic [COLS-1:0]              COL_EN,
  output logic [ROWS-1:0]              ROW_DATA,
  output logic                         FRAME_DONE,
  input  logic [$clog2(COLS+1)-1:0]    PIX_COL,
  input  logic [$clog2(ROWS+1)-1:0]    PIX_ROW,
  output logic                         PIX_OUT
);

  localparam int N    = COLS * ROWS;
  localparam int CW   = $clog2(COLS + 1);
  localparam int RW   = $clog2(ROWS + 1);
  localparam int CLW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t            state_q, state_d;
  logic [CLW-1:0]    col_q, col_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]      active_q, active_d;
  logic [N-1:0]      shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic [COLS-1:0]   col_en_q, col_en_d;
  logic [ROWS-1:0]   row_data_q, row_data_d;
  logic              frame_done_q, frame_done_d;
  logic              pix_out_q, pix_out_d;
  logic              load_ready_q, load_ready_d;
  logic              last_col, wrap;
  logic [CLW-1:0]    next_col;

  function automatic logic [ROWS-1:0] col_bits(input logic [N-1:0] f, input logic [CLW-1:0] c);
    col_bits = '0;
    for (int i = 0; i < COLS; i++)
      if (c == CLW'(i)) col_bits = f[i*ROWS +: ROWS];
  endfunction

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    wrap         = 1'b0;
    last_col     = (col_q == CLW'(COLS - 1));
    next_col     = last_col ? '0 : col_q + 1'b1;

    if (LOAD_VALID && load_ready_q) begin
      shadow_d  = FRAME_IN;
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (EN) begin
          state_d = SHOW;
          col_d   = '0;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (!EN) begin
          state_d = IDLE;
          col_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNTW'(DWELL - 1)) begin
          cnt_d = '0;
          if (BLANK > 0) begin
            state_d = GAP;
          end else begin
            col_d = next_col;
            wrap  = last_col;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (!EN) begin
          state_d = IDLE;
          col_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNTW'(BLANK - 1)) begin
          state_d = SHOW;
          cnt_d   = '0;
          col_d   = next_col;
          wrap    = last_col;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        col_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // The active buffer only changes between frames or while idle, never mid-frame.
    if (pending_q && (wrap || state_q == IDLE)) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    // Ready drops right after a load but only rises one cycle after the promotion.
    load_ready_d = !(pending_q || pending_d);
    frame_done_d = wrap;
    col_en_d     = (state_d == SHOW) ? (COLS'(1) << col_d) : '0;
    row_data_d   = (state_d == SHOW) ? col_bits(active_d, col_d) : '0;

    pix_out_d = 1'b0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (PIX_COL == CW'(c + 1) && PIX_ROW == RW'(r + 1))
          pix_out_d = active_q[c*ROWS + r];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      col_q        <= '0;
      cnt_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      col_en_q     <= '0;
      row_data_q   <= '0;
      frame_done_q <= 1'b0;
      pix_out_q    <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      col_en_q     <= col_en_d;
      row_data_q   <= row_data_d;
      frame_done_q <= frame_done_d;
      pix_out_q    <= pix_out_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign COL_EN     = col_en_q;
  assign ROW_DATA   = row_data_q;
  assign FRAME_DONE = frame_done_q;
  assign PIX_OUT    = pix_out_q;
  assign LOAD_READY = load_ready_q;

endmodule
